prog_instruction_memory: RTL and testbench

- Parametrised instruction store, loaded chunk-by-chunk from front-panel switches on a push-button strobe, read by the fetch stage.
- Generalises the fixed 16-bit x 64 button loader:
  - configurable instruction width, depth and chunk width;
  - button synchronised into the clk domain;
  - atomic word commit, load/run mode, rewind, full flag and word count.

---
 rtl/prog_instruction_memory_pkg.sv | 28 ++
 rtl/prog_instruction_memory_if.sv | 35 +++
 rtl/prog_instruction_memory_button_edge_sync.sv | 29 ++
 rtl/prog_instruction_memory.sv | 124 ++++++++++++
 tb/tb_prog_instruction_memory.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_instruction_memory_pkg.sv
// Shared definitions for the front-panel instruction store: default sizes,
// the default word type and the helper that positions one switch chunk.
package prog_instruction_memory_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int DEPTH_DEF   = 64;
  localparam int CHUNK_W_DEF = 6;
  localparam int SLICE_W     = 64;

  typedef logic [INSTR_W_DEF-1:0] word_t;
  typedef logic [SLICE_W-1:0]     slice_t;

  // Chunk k lands MSB-first at bit (instr_w - (k+1)*chunk_w). The final
  // chunk may be narrower than chunk_w: it is right-aligned to bit 0 and the
  // surplus upper bits of the switch value are dropped.
  function automatic slice_t chunk_slice(input slice_t chunk, input int k,
                                         input int instr_w, input int chunk_w);
    int     lsb;
    int     width;
    slice_t mask;
    lsb   = instr_w - (k + 1) * chunk_w;
    width = (lsb < 0) ? (chunk_w + lsb) : chunk_w;
    if (lsb < 0) lsb = 0;
    mask  = (slice_t'(1) << width) - slice_t'(1);
    return (chunk & mask) << lsb;
  endfunction

endpackage

// File: rtl/prog_instruction_memory_if.sv
// Bus between the front panel / fetch stage and the instruction store.
interface prog_instruction_memory_if
  import prog_instruction_memory_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NCHUNK  = (INSTR_W + CHUNK_W - 1) / CHUNK_W,
  parameter int CIDX_W  = $clog2(NCHUNK) + 1
) ();

  logic               clk_enable;
  logic               load_mode;
  logic               button;
  logic [CHUNK_W-1:0] chunk_in;
  logic               rewind;
  logic [ADDR_W-1:0]  read_address;
  logic [INSTR_W-1:0] instruction_out;
  logic [ADDR_W:0]    word_count;
  logic [CIDX_W-1:0]  chunk_idx;
  logic               full;
  logic               word_done;

  modport master (
    output clk_enable, load_mode, button, chunk_in, rewind, read_address,
    input  instruction_out, word_count, chunk_idx, full, word_done
  );

  modport slave (
    input  clk_enable, load_mode, button, chunk_in, rewind, read_address,
    output instruction_out, word_count, chunk_idx, full, word_done
  );

endinterface

// File: rtl/prog_instruction_memory_button_edge_sync.sv
// Brings an asynchronous, externally debounced push-button into the clk
// domain and emits a single-cycle pulse on each press.
module button_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic pulse
);

  logic sync_meta;
  logic sync_q;
  logic prev_q;

  // Two-flop synchroniser followed by a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      sync_meta <= button;
      sync_q    <= sync_meta;
      prev_q    <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/prog_instruction_memory.sv
// Instruction store loaded chunk-by-chunk from front-panel switches on a
// button strobe and read by the fetch stage through a registered port.
module prog_instruction_memory
  import prog_instruction_memory_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NCHUNK  = (INSTR_W + CHUNK_W - 1) / CHUNK_W
) (
  input logic                      clk,
  input logic                      reset,
  prog_instruction_memory_if.slave bus
);

  localparam int                CIDX_W     = $clog2(NCHUNK) + 1;
  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NCHUNK - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic               press;
  logic               strobe;
  logic               full;
  logic               commit;
  logic [CIDX_W-1:0]  chunk_idx_q;
  logic [CIDX_W-1:0]  chunk_idx_d;
  logic [ADDR_W:0]    word_count_q;
  logic [ADDR_W:0]    word_count_d;
  logic [INSTR_W-1:0] assembly_q;
  logic [INSTR_W-1:0] assembly_d;
  logic               word_done_q;
  logic [INSTR_W-1:0] chunk_placed;
  logic [INSTR_W-1:0] commit_word;
  logic [INSTR_W-1:0] read_data;
  logic [INSTR_W-1:0] instruction_q;
  logic [INSTR_W-1:0] mem [DEPTH];

  button_edge_sync u_button (
    .clk    (clk),
    .reset  (reset),
    .button (bus.button),
    .pulse  (press)
  );

  // The assembly register only ever holds earlier chunks, so OR-ing the
  // current chunk in at its slot yields the partial or complete word.
  assign chunk_placed = INSTR_W'(chunk_slice(slice_t'(bus.chunk_in),
                                             int'(chunk_idx_q), INSTR_W, CHUNK_W));
  assign commit_word  = assembly_q | chunk_placed;

  // Derived controls: full flag, accepted strobe and whole-word commit.
  always_comb begin
    full   = (word_count_q == FULL_COUNT);
    strobe = press & bus.load_mode & ~full;
    commit = strobe & ~bus.rewind & (chunk_idx_q == LAST_CHUNK);
  end

  // Next state: rewind beats everything, leaving load mode drops the
  // partial word, otherwise a strobe advances the chunk index.
  always_comb begin
    chunk_idx_d  = chunk_idx_q;
    word_count_d = word_count_q;
    assembly_d   = assembly_q;
    if (bus.rewind) begin
      chunk_idx_d  = '0;
      word_count_d = '0;
      assembly_d   = '0;
    end else if (!bus.load_mode) begin
      chunk_idx_d  = '0;
      assembly_d   = '0;
    end else if (commit) begin
      chunk_idx_d  = '0;
      word_count_d = word_count_q + (ADDR_W + 1)'(1);
      assembly_d   = '0;
    end else if (strobe) begin
      chunk_idx_d  = chunk_idx_q + CIDX_W'(1);
      assembly_d   = commit_word;
    end
  end

  // Loader state register; word_done is the registered commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chunk_idx_q  <= '0;
      word_count_q <= '0;
      assembly_q   <= '0;
      word_done_q  <= 1'b0;
    end else begin
      chunk_idx_q  <= chunk_idx_d;
      word_count_q <= word_count_d;
      assembly_q   <= assembly_d;
      word_done_q  <= commit;
    end
  end

  // Storage array; only complete words are written and it is never reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[word_count_q[ADDR_W-1:0]] <= commit_word;
    end
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_read_pow2
    assign read_data = mem[bus.read_address];
  end else begin : g_read_guard
    assign read_data = (bus.read_address < ADDR_W'(DEPTH)) ? mem[bus.read_address] : '0;
  end

  // Registered read port, gated by the processor step/run enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_q <= '0;
    end else if (bus.clk_enable) begin
      instruction_q <= read_data;
    end
  end

  assign bus.instruction_out = instruction_q;
  assign bus.word_count      = word_count_q;
  assign bus.chunk_idx       = chunk_idx_q;
  assign bus.full            = full;
  assign bus.word_done       = word_done_q;

endmodule

// File: tb/tb_prog_instruction_memory.sv
// Self-checking bench for prog_instruction_memory at default parameters.
module tb_prog_instruction_memory;
  import prog_instruction_memory_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_instruction_memory_if bus ();

  prog_instruction_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    tests = 0;
  int    fails = 0;
  int    done_cnt = 0;
  int    model_wc = 0;
  word_t model_mem [64];
  word_t exp_q [$];

  // Count word_done pulses, sampled well after the rising edge.
  always @(posedge clk) begin
    #2;
    if (bus.word_done === 1'b1) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] chunk_of(input word_t w, input int k, input logic [1:0] pad);
    logic [5:0] c;
    case (k)
      0:       c = w[15:10];
      1:       c = w[9:4];
      default: c = {pad, w[3:0]};
    endcase
    return c;
  endfunction

  task automatic press(input logic [5:0] c);
    @(negedge clk);
    bus.chunk_in = c;
    bus.button   = 1'b1;
    repeat (3) @(negedge clk);
    bus.button   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_word(input word_t w, input logic [1:0] pad);
    for (int k = 0; k < 3; k++) press(chunk_of(w, k, pad));
    model_mem[model_wc] = w;
    model_wc++;
  endtask

  task automatic do_read(input logic [5:0] addr, input string name);
    word_t e;
    @(negedge clk);
    bus.read_address = addr;
    bus.clk_enable   = 1'b1;
    exp_q.push_back(model_mem[addr]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (bus.instruction_out !== e) begin
      fails++;
      $display("FAIL %s: instruction_out=%h expected %h", name, bus.instruction_out, e);
    end
    @(negedge clk);
    bus.clk_enable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests += 5;
    if (bus.word_count !== 7'd0) begin fails++; $display("FAIL reset_wc: %0d expected 0", bus.word_count); end
    if (bus.chunk_idx !== 3'd0) begin fails++; $display("FAIL reset_ci: %0d expected 0", bus.chunk_idx); end
    if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: %b expected 0", bus.full); end
    if (bus.word_done !== 1'b0) begin fails++; $display("FAIL reset_done: %b expected 0", bus.word_done); end
    if (bus.instruction_out !== 16'h0000) begin fails++; $display("FAIL reset_iout: %h expected 0000", bus.instruction_out); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_one();
    int d0;
    bus.load_mode = 1'b1;
    d0 = done_cnt;
    press(6'h01);
    tests++;
    if (bus.chunk_idx !== 3'd1) begin fails++; $display("FAIL load_ci1: %0d expected 1", bus.chunk_idx); end
    press(6'h08);
    tests++;
    if (bus.chunk_idx !== 3'd2) begin fails++; $display("FAIL load_ci2: %0d expected 2", bus.chunk_idx); end
    press(6'h01);
    model_mem[0] = 16'h0481;
    model_wc = 1;
    tests += 3;
    if (bus.chunk_idx !== 3'd0) begin fails++; $display("FAIL load_ci0: %0d expected 0", bus.chunk_idx); end
    if (bus.word_count !== 7'(model_wc)) begin fails++; $display("FAIL load_wc: %0d expected %0d", bus.word_count, model_wc); end
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL load_done: %0d pulses expected 1", done_cnt - d0); end
    do_read(6'd0, "load_read0");
  endtask

  task automatic test_abort();
    press(6'h3F);
    press(6'h3F);
    tests++;
    if (bus.chunk_idx !== 3'd2) begin fails++; $display("FAIL abort_pre: %0d expected 2", bus.chunk_idx); end
    @(negedge clk);
    bus.load_mode = 1'b0;
    @(negedge clk);
    tests += 2;
    if (bus.chunk_idx !== 3'd0) begin fails++; $display("FAIL abort_ci: %0d expected 0", bus.chunk_idx); end
    if (bus.word_count !== 7'(model_wc)) begin fails++; $display("FAIL abort_wc: %0d expected %0d", bus.word_count, model_wc); end
    bus.load_mode = 1'b1;
    load_word(16'h1234, 2'b11);
    tests++;
    if (bus.word_count !== 7'(model_wc)) begin fails++; $display("FAIL abort_wc2: %0d expected %0d", bus.word_count, model_wc); end
    do_read(6'd0, "abort_read0");
    do_read(6'd1, "abort_read1");
  endtask

  task automatic test_run_mode();
    bus.load_mode = 1'b0;
    press(6'h2A);
    tests += 2;
    if (bus.chunk_idx !== 3'd0) begin fails++; $display("FAIL run_ci: %0d expected 0", bus.chunk_idx); end
    if (bus.word_count !== 7'(model_wc)) begin fails++; $display("FAIL run_wc: %0d expected %0d", bus.word_count, model_wc); end
    bus.load_mode = 1'b1;
  endtask

  task automatic test_rewind_priority();
    word_t w;
    w = 16'hBEEF;
    press(chunk_of(w, 0, 2'b00));
    press(chunk_of(w, 1, 2'b00));
    @(negedge clk);
    bus.chunk_in = chunk_of(w, 2, 2'b00);
    bus.button   = 1'b1;
    repeat (2) @(negedge clk);
    bus.rewind = 1'b1;
    @(negedge clk);
    bus.rewind = 1'b0;
    bus.button = 1'b0;
    model_wc = 0;
    tests += 3;
    if (bus.word_count !== 7'd0) begin fails++; $display("FAIL rewind_wc: %0d expected 0", bus.word_count); end
    if (bus.chunk_idx !== 3'd0) begin fails++; $display("FAIL rewind_ci: %0d expected 0", bus.chunk_idx); end
    if (bus.full !== 1'b0) begin fails++; $display("FAIL rewind_full: %b expected 0", bus.full); end
    repeat (3) @(negedge clk);
    do_read(6'd0, "rewind_read0");
    do_read(6'd1, "rewind_read1");
  endtask

  task automatic test_fill();
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < 64; n++) begin
      load_word(word_t'(n), 2'b10);
      if (n == 62) begin
        tests++;
        if (bus.full !== 1'b0) begin fails++; $display("FAIL fill_full63: %b expected 0", bus.full); end
      end
    end
    tests += 3;
    if (bus.full !== 1'b1) begin fails++; $display("FAIL fill_full: %b expected 1", bus.full); end
    if (bus.word_count !== 7'd64) begin fails++; $display("FAIL fill_wc: %0d expected 64", bus.word_count); end
    if (done_cnt - d0 !== 64) begin fails++; $display("FAIL fill_done: %0d pulses expected 64", done_cnt - d0); end
    d0 = done_cnt;
    press(6'h15);
    tests += 4;
    if (bus.word_count !== 7'd64) begin fails++; $display("FAIL full_wc: %0d expected 64", bus.word_count); end
    if (bus.chunk_idx !== 3'd0) begin fails++; $display("FAIL full_ci: %0d expected 0", bus.chunk_idx); end
    if (bus.full !== 1'b1) begin fails++; $display("FAIL full_flag: %b expected 1", bus.full); end
    if (done_cnt !== d0) begin fails++; $display("FAIL full_done: %0d pulses expected 0", done_cnt - d0); end
    do_read(6'd63, "fill_read63");
    do_read(6'd0, "fill_read0");
  endtask

  task automatic test_read_hold();
    word_t e;
    do_read(6'd5, "hold_read5");
    @(negedge clk);
    bus.clk_enable   = 1'b0;
    bus.read_address = 6'd63;
    exp_q.push_back(model_mem[5]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (bus.instruction_out !== e) begin fails++; $display("FAIL hold: instruction_out=%h expected %h", bus.instruction_out, e); end
  endtask

  task automatic test_same_addr();
    word_t w;
    word_t e;
    @(negedge clk);
    bus.rewind = 1'b1;
    @(negedge clk);
    bus.rewind = 1'b0;
    model_wc = 0;
    tests += 2;
    if (bus.full !== 1'b0) begin fails++; $display("FAIL rw_full: %b expected 0", bus.full); end
    if (bus.word_count !== 7'd0) begin fails++; $display("FAIL rw_wc: %0d expected 0", bus.word_count); end
    w = 16'hABCD;
    press(chunk_of(w, 0, 2'b00));
    press(chunk_of(w, 1, 2'b00));
    @(negedge clk);
    bus.chunk_in = chunk_of(w, 2, 2'b01);
    bus.button   = 1'b1;
    repeat (2) @(negedge clk);
    bus.read_address = 6'd0;
    bus.clk_enable   = 1'b1;
    exp_q.push_back(model_mem[0]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (bus.instruction_out !== e) begin fails++; $display("FAIL collide_old: instruction_out=%h expected %h", bus.instruction_out, e); end
    @(negedge clk);
    bus.clk_enable = 1'b0;
    bus.button     = 1'b0;
    model_mem[0] = w;
    model_wc = 1;
    repeat (3) @(negedge clk);
    do_read(6'd0, "collide_new");
  endtask

  task automatic test_async_reset();
    press(6'h2B);
    tests++;
    if (bus.chunk_idx !== 3'd1) begin fails++; $display("FAIL ar_pre: %0d expected 1", bus.chunk_idx); end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests += 5;
    if (bus.word_count !== 7'd0) begin fails++; $display("FAIL ar_wc: %0d expected 0", bus.word_count); end
    if (bus.chunk_idx !== 3'd0) begin fails++; $display("FAIL ar_ci: %0d expected 0", bus.chunk_idx); end
    if (bus.full !== 1'b0) begin fails++; $display("FAIL ar_full: %b expected 0", bus.full); end
    if (bus.word_done !== 1'b0) begin fails++; $display("FAIL ar_done: %b expected 0", bus.word_done); end
    if (bus.instruction_out !== 16'h0000) begin fails++; $display("FAIL ar_iout: %h expected 0000", bus.instruction_out); end
    @(negedge clk);
    reset = 1'b1;
    model_wc = 0;
    repeat (2) @(negedge clk);
    do_read(6'd0, "ar_mem_kept");
  endtask

  task automatic test_narrow_pulse();
    word_t w;
    w = 16'h5A5A;
    @(negedge clk);
    bus.chunk_in = chunk_of(w, 0, 2'b00);
    #3;
    bus.button = 1'b1;
    #4;
    bus.button = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (bus.chunk_idx !== 3'd1) begin fails++; $display("FAIL narrow: chunk_idx=%0d expected 1", bus.chunk_idx); end
    bus.chunk_in = chunk_of(w, 1, 2'b00);
    bus.button   = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (bus.chunk_idx !== 3'd2) begin fails++; $display("FAIL held: chunk_idx=%0d expected 2", bus.chunk_idx); end
    bus.button = 1'b0;
    repeat (3) @(negedge clk);
    press(chunk_of(w, 2, 2'b11));
    model_mem[0] = w;
    model_wc = 1;
    tests++;
    if (bus.word_count !== 7'(model_wc)) begin fails++; $display("FAIL narrow_wc: %0d expected %0d", bus.word_count, model_wc); end
    do_read(6'd0, "narrow_read0");
  endtask

  initial begin
    reset            = 1'b0;
    bus.clk_enable   = 1'b0;
    bus.load_mode    = 1'b0;
    bus.button       = 1'b0;
    bus.chunk_in     = '0;
    bus.rewind       = 1'b0;
    bus.read_address = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    test_reset();
    test_load_one();
    test_abort();
    test_run_mode();
    test_rewind_priority();
    test_fill();
    test_read_hold();
    test_same_addr();
    test_async_reset();
    test_narrow_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
